hazard_unit: RTL and testbench

- Pipeline hazard controller for the 5-stage RV32 core.
- Produces the stall (enable) and clear/flush controls that drive the inter-stage pipeline registers, plus the E-stage forwarding selects.
- Contains a small FSM/counter that holds the pipeline while a multi-cycle multiply/divide instruction occupies the Execute stage.
- Sits upstream of every F/D, D/E and E/M pipeline register: its Flush* outputs connect to their clear inputs, and its Stall* outputs gate their enables.

---
 rtl/hazard_unit.sv | 129 ++++++++++++
 tb/tb_hazard_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage RV32 pipeline: forwarding selects, load-use
// and mul/div stalls, and flush controls for the F/D, D/E and E/M registers.
module hazard_unit #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 16,
    parameter int CNT_W      = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       ResultSrcE0,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       PCSrcE,
    input  logic       MdStartE,
    input  logic       MdDivE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic       MdBusy,
    output logic       MdDone
);

    // state | meaning
    // IDLE  | no mul/div holding E; a new MdStartE loads the counter
    // BUSY  | mul/div counting down; counter zero is the completion cycle
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES - 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_stall;
    logic             md_done;
    logic             lw_stall;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (RegWriteM && (RdM == rs) && (RdM != 5'd0)) begin
            sel = 2'b10;
        end else if (RegWriteW && (RdW == rs) && (RdW != 5'd0)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        md_stall = 1'b0;
        md_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (MdStartE) begin
                    md_stall = 1'b1;
                    cnt_d    = MdDivE ? DIV_LD : MUL_LD;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    md_stall = 1'b1;
                    cnt_d    = cnt_q - CNT_W'(1);
                end else begin
                    // Instruction leaves E at the end of this cycle, so the
                    // IDLE cycle that follows sees the next instruction.
                    md_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        FlushM    = 1'b1;
        MdBusy    = 1'b0;
        MdDone    = 1'b0;
        if (!reset) begin
            ForwardAE = fwd_sel(Rs1E);
            ForwardBE = fwd_sel(Rs2E);
            StallF    = lw_stall || md_stall;
            StallD    = lw_stall || md_stall;
            StallE    = md_stall;
            // A held mul/div must not be squashed by a branch in the same slot.
            FlushD    = PCSrcE && !md_stall;
            FlushE    = (lw_stall || PCSrcE) && !md_stall;
            FlushM    = md_stall;
            MdBusy    = (state_q == BUSY);
            MdDone    = md_done;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: vector table for the combinational rules,
// hand-written sequences for the mul/div FSM and mid-operation reset.
module tb_hazard_unit;

    typedef struct packed {
        logic       reset;
        logic [4:0] rs1d;
        logic [4:0] rs2d;
        logic [4:0] rs1e;
        logic [4:0] rs2e;
        logic [4:0] rde;
        logic [4:0] rdm;
        logic [4:0] rdw;
        logic       lw;
        logic       rwm;
        logic       rww;
        logic       pcsrc;
        logic       mdstart;
        logic       mddiv;
    } in_t;

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic       sf;
        logic       sd;
        logic       se;
        logic       fd;
        logic       fe;
        logic       fm;
        logic       busy;
        logic       done;
    } out_t;

    typedef struct {
        string name;
        in_t   in;
        out_t  exp;
    } vec_t;

    typedef struct {
        string name;
        out_t  exp;
    } sb_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MdStartE, MdDivE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy, MdDone;

    int   n_checks = 0;
    int   n_fail   = 0;
    sb_t  sb[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    hazard_unit #(.MUL_CYCLES(2), .DIV_CYCLES(16), .CNT_W(5)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .MdStartE(MdStartE), .MdDivE(MdDivE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .MdBusy(MdBusy), .MdDone(MdDone)
    );

    function automatic out_t mk(input logic [1:0] fa, input logic [1:0] fb, input logic stall_fd,
                                input logic se, input logic fd, input logic fe, input logic fm,
                                input logic busy, input logic done);
        out_t o;
        o.fa = fa; o.fb = fb; o.sf = stall_fd; o.sd = stall_fd; o.se = se;
        o.fd = fd; o.fe = fe; o.fm = fm; o.busy = busy; o.done = done;
        return o;
    endfunction

    task automatic drive(input string nm, input in_t i, input out_t e);
        sb_t s;
        @(posedge clk);
        #1;
        reset = i.reset; Rs1D = i.rs1d; Rs2D = i.rs2d; Rs1E = i.rs1e; Rs2E = i.rs2e;
        RdE = i.rde; RdM = i.rdm; RdW = i.rdw; ResultSrcE0 = i.lw;
        RegWriteM = i.rwm; RegWriteW = i.rww; PCSrcE = i.pcsrc;
        MdStartE = i.mdstart; MdDivE = i.mddiv;
        s.name = nm;
        s.exp  = e;
        sb.push_back(s);
    endtask

    always @(negedge clk) begin
        sb_t  s;
        out_t act;
        if (sb.size() > 0) begin
            s   = sb.pop_front();
            act = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy, MdDone};
            n_checks++;
            if (act !== s.exp) begin
                n_fail++;
                $display("FAIL %s: got fa,fb,sF,sD,sE,fD,fE,fM,busy,done=%b expected %b", s.name, act, s.exp);
            end
        end
    end

    // One mul/div instruction held in E for s+1 cycles; PCSrcE raised on cycles pc_lo..pc_hi.
    task automatic run_md(input string nm, input logic div, input int s, input int pc_lo, input int pc_hi);
        in_t  v;
        out_t e;
        logic st;
        for (int c = 1; c <= s + 1; c++) begin
            v = '0;
            v.mdstart = 1'b1;
            v.mddiv   = div;
            v.pcsrc   = (c >= pc_lo) && (c <= pc_hi);
            st = (c <= s);
            e = mk(2'b00, 2'b00, st, st, v.pcsrc && !st, v.pcsrc && !st, st, c >= 2, c == s + 1);
            drive($sformatf("%s_c%0d", nm, c), v, e);
        end
    endtask

    initial begin
        in_t  v;
        out_t e;
        out_t rst_o;
        out_t idle_o;

        reset = 1'b1; Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        ResultSrcE0 = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b0;
        MdStartE = 1'b0; MdDivE = 1'b0;

        rst_o  = mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle_o = mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        v = '0; v.reset = 1'b1; v.rwm = 1'b1; v.rdm = 5'd5; v.rs1e = 5'd5;
        v.lw = 1'b1; v.rde = 5'd3; v.rs2d = 5'd3;
        vecs.push_back('{"reset_override", v, rst_o});
        v = '0; v.reset = 1'b1; v.mdstart = 1'b1;
        vecs.push_back('{"reset_mdstart", v, rst_o});
        v = '0;
        vecs.push_back('{"idle_zero", v, idle_o});
        v = '0; v.rwm = 1'b1; v.rdm = 5'd5; v.rs1e = 5'd5; v.rww = 1'b1; v.rdw = 5'd5;
        vecs.push_back('{"fwdA_M_over_W", v, mk(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0)});
        v.rdm = 5'd0;
        vecs.push_back('{"fwdA_W_rdm0", v, mk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0)});
        v.rs2e = 5'd7;
        vecs.push_back('{"fwdB_none", v, mk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0)});
        v = '0; v.rwm = 1'b1; v.rdm = 5'd9; v.rs2e = 5'd9; v.rww = 1'b1; v.rdw = 5'd4; v.rs1e = 5'd4;
        vecs.push_back('{"fwdB_M_fwdA_W", v, mk(2'b01, 2'b10, 0, 0, 0, 0, 0, 0, 0)});
        v = '0; v.rdm = 5'd5; v.rdw = 5'd5; v.rs1e = 5'd5; v.rs2e = 5'd5;
        vecs.push_back('{"fwd_no_regwrite", v, idle_o});
        v = '0; v.rwm = 1'b1; v.rww = 1'b1;
        vecs.push_back('{"fwd_x0", v, idle_o});
        v = '0; v.lw = 1'b1; v.rde = 5'd3; v.rs2d = 5'd3;
        vecs.push_back('{"loaduse_rs2", v, mk(2'b00, 2'b00, 1, 0, 0, 1, 0, 0, 0)});
        v = '0;
        vecs.push_back('{"loaduse_released", v, idle_o});
        v = '0; v.lw = 1'b1; v.rde = 5'd6; v.rs1d = 5'd6;
        vecs.push_back('{"loaduse_rs1", v, mk(2'b00, 2'b00, 1, 0, 0, 1, 0, 0, 0)});
        v = '0; v.lw = 1'b1;
        vecs.push_back('{"loaduse_rd0", v, idle_o});
        v = '0; v.lw = 1'b1; v.rde = 5'd3; v.rs1d = 5'd4; v.rs2d = 5'd5;
        vecs.push_back('{"load_nomatch", v, idle_o});
        v = '0; v.rde = 5'd3; v.rs2d = 5'd3;
        vecs.push_back('{"nonload_match", v, idle_o});
        v = '0; v.pcsrc = 1'b1;
        vecs.push_back('{"branch", v, mk(2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0)});
        v = '0; v.pcsrc = 1'b1; v.lw = 1'b1; v.rde = 5'd3; v.rs1d = 5'd3;
        vecs.push_back('{"branch_loaduse", v, mk(2'b00, 2'b00, 1, 0, 1, 1, 0, 0, 0)});

        foreach (vecs[k]) drive(vecs[k].name, vecs[k].in, vecs[k].exp);

        // Back-to-back multiplies: MdStartE stays high into the next instruction.
        run_md("mul1", 1'b0, 2, 0, 0);
        run_md("mul2", 1'b0, 2, 0, 0);
        v = '0;
        drive("mul_idle_after", v, idle_o);

        // Divide with a branch raised during the stall: flushes suppressed.
        run_md("div", 1'b1, 16, 3, 4);
        v = '0;
        drive("div_idle_after", v, idle_o);

        // Reset at stall cycle 5 of a divide, then check nothing resumes.
        for (int c = 1; c <= 4; c++) begin
            v = '0; v.mdstart = 1'b1; v.mddiv = 1'b1;
            e = mk(2'b00, 2'b00, 1, 1, 0, 0, 1, c >= 2, 0);
            drive($sformatf("rdiv_c%0d", c), v, e);
        end
        v = '0; v.reset = 1'b1; v.mdstart = 1'b1; v.mddiv = 1'b1;
        drive("rdiv_reset_c5", v, rst_o);
        v = '0; v.reset = 1'b1;
        drive("rdiv_reset_hold", v, rst_o);
        for (int c = 0; c < 18; c++) begin
            v = '0;
            drive($sformatf("rdiv_after_%0d", c), v, idle_o);
        end

        @(negedge clk);
        @(posedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending checks expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

endmodule
